mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multi-cycle main control FSM for the miniMIPS datapath.
- Sits directly upstream of the ALU control unit. Decodes the 4-bit opcode held in the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and mux selects, plus the 3-bit alu_op consumed by the ALU control unit.
- Memory accesses use a ready handshake, so slow memory stalls the FSM in place.

Parameters:
- PC_INC, 2'b01: alu_src_b select used for PC increment (constant 2, 16-bit words).
- RESET_STATE, 4'd0: state entered on reset (FETCH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode  in  4  IR[15:12], stable from the cycle after ir_write
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  0 = PC address, 1 = ALUOut address
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 = regB, 01 = const 2, 10 = sign-extended imm, 11 = imm<<1
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_op  out  3  to the ALU control unit
- state_o  out  4  current state, for debug/verification
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst=1): state=FETCH; illegal=0.
- Outputs are Moore-decoded from state and the registered opcode, except the pc_write terms that use mem_ready/zero. Outputs not listed for a state are 0.
- alu_op codes:
  - 000 RTYPE (use func)
  - 010 ADD
  - 100 SUB
  - 101 AND
  - 110 OR
  - 111 SLT
- Opcodes:
  - 0 R-type, 1 addi, 2 andi, 3 ori, 4 slti
  - 5 lw, 6 sw, 7 beq, 8 bne, 9 j
  - 10-15 illegal
- FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=PC_INC, alu_op=ADD, pc_source=00. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then DECODE. No PC/IR update while mem_ready=0.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 0 -> RTEXE
  - 1-4 -> IMMEXE
  - 5/6 -> MEMADR
  - 7/8 -> BRANCH
  - 9 -> JUMP
  - else -> ILLEGAL
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR(5): mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- RTEXE(6): alu_src_a=1, alu_src_b=00, alu_op=RTYPE. Next RTWB.
- RTWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- IMMEXE(8): alu_src_a=1, alu_src_b=10. alu_op is ADD/AND/OR/SLT for addi/andi/ori/slti. Next IMMWB.
- IMMWB(9): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write = (beq & zero) | (bne & ~zero). Next FETCH.
- JUMP(11): pc_source=10, pc_write=1. Next FETCH.
- ILLEGAL(12): all enables 0, illegal=1. Stays in ILLEGAL until rst.
- Unused encodings 13-15 go to ILLEGAL next cycle.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and pc_write are never both 1.
- Latencies with zero wait states:
  - 3 cycles: j, beq, bne
  - 4 cycles: R-type, immediate ops, sw
  - 5 cycles: lw
  - Each mem_ready=0 cycle adds one cycle.
- rst asserted mid-instruction: immediate return to FETCH with all enables 0. No partial register or memory write completes after the rst edge.

Decomposition:
- Package mips_ctrl_pkg: state enum (4-bit), alu_op constants, opcode constants, alu_src_b and pc_source select constants.
- One sub-module, mips_ctrl_decode: purely combinational state+opcode -> control-word decoder. The top holds only the state register and next-state logic.

Test Plan:
- rst=1 then release, opcode=0, mem_ready=1 -> state_o sequence 0,1,6,7,0. RTEXE has alu_op=000; RTWB has reg_write=1, reg_dst=1.
- lw (opcode=5), mem_ready low for 2 cycles in MEMRD -> state_o sequence 0,1,2,3,3,3,4,0. MEMWB has mem_to_reg=1, reg_write=1.
- beq (opcode=7) with zero=1 -> pc_write=1, pc_source=01 in BRANCH. Repeat with zero=0 -> pc_write=0. bne (opcode=8), zero=0 -> pc_write=1.
- ori (opcode=3) -> IMMEXE has alu_op=110, alu_src_b=10. Then IMMWB with reg_write=1, reg_dst=0.
- opcode=4'hF -> state 0,1,12. illegal=1 is held for 20 cycles. rst pulse returns to FETCH with illegal=0.
- rst asserted asynchronously mid-MEMWR (mem_write=1) -> mem_write drops before the next clk edge and state_o=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the miniMIPS multi-cycle control unit:
// FSM states, ALU operation codes, opcodes, mux selects and the control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_IMMEXE  = 4'd8,
        S_IMMWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam state_t RESET_STATE = S_FETCH;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_J     = 4'd9;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] PC_INC     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_SLTI: imm_alu_op = ALU_SLT;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-word decoder: maps the current FSM state and the
// registered opcode (plus mem_ready/zero for the PC write terms) to datapath controls.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = PC_INC;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            // Speculatively form the branch target while the opcode is decoded
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SHIFT;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_RTEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IMMEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_alu_op(opcode);
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_OUT;
                ctrl.pc_write  = ((opcode == OP_BEQ) && zero) ||
                                 ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control FSM for the miniMIPS datapath: holds the state
// register and next-state logic; the control word comes from mips_ctrl_decode.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state_o,
    output logic       illegal
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RESET_STATE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_ILLEGAL;
        case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                          next_state = S_RTEXE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IMMEXE;
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:                    next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    default:                           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXE:   next_state = S_RTWB;
            S_RTWB:    next_state = S_FETCH;
            S_IMMEXE:  next_state = S_IMMWB;
            S_IMMWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_ILLEGAL;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_dec)
    );

    // Reset blanks every enable immediately, even before the state register settles
    always_comb begin
        ctrl = ctrl_dec;
        if (rst)
            ctrl = '0;
    end

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign iord       = ctrl.iord;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;
    assign state_o    = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each stimulus cycle queues the
// hand-computed state and control word, and a monitor compares them on the falling edge.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    // Control word layout: {pc_write, ir_write, mem_read, mem_write, iord, reg_write,
    // reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[2:0], illegal}
    localparam logic [16:0] PCW = 17'h10000, IRW = 17'h08000, MRD = 17'h04000, MWR = 17'h02000;
    localparam logic [16:0] IORD = 17'h01000, RW = 17'h00800, RDST = 17'h00400, M2R = 17'h00200;
    localparam logic [16:0] SRCA = 17'h00100, SRCB_2 = 17'h00040, SRCB_IMM = 17'h00080, SRCB_SH = 17'h000C0;
    localparam logic [16:0] PCS_OUT = 17'h00010, PCS_J = 17'h00020;
    localparam logic [16:0] OP_ADD = 17'h00004, OP_SUB = 17'h00008, OP_OR = 17'h0000C, ILL = 17'h00001;

    localparam logic [16:0] W_FETCH   = PCW | IRW | MRD | SRCB_2 | OP_ADD;
    localparam logic [16:0] W_FSTALL  = MRD | SRCB_2 | OP_ADD;
    localparam logic [16:0] W_DECODE  = SRCB_SH | OP_ADD;
    localparam logic [16:0] W_MEMADR  = SRCA | SRCB_IMM | OP_ADD;
    localparam logic [16:0] W_MEMRD   = MRD | IORD;
    localparam logic [16:0] W_MEMWB   = RW | M2R;
    localparam logic [16:0] W_MEMWR   = MWR | IORD;
    localparam logic [16:0] W_RTEXE   = SRCA;
    localparam logic [16:0] W_RTWB    = RW | RDST;
    localparam logic [16:0] W_BR_T    = SRCA | OP_SUB | PCS_OUT | PCW;
    localparam logic [16:0] W_BR_N    = SRCA | OP_SUB | PCS_OUT;
    localparam logic [16:0] W_JUMP    = PCS_J | PCW;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [16:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    event sample_now;

    mips_multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic pushExpect(input string nm, input logic [3:0] es, input logic [16:0] ew);
        exp_t e;
        e.name = nm;
        e.st   = es;
        e.word = ew;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive inputs just after the rising edge and queue the expectation
    task automatic applyStimulus(input logic r, input logic [3:0] op, input logic z,
                                 input logic mr, input logic [3:0] es,
                                 input logic [16:0] ew, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        pushExpect(nm, es, ew);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [16:0] got;
        got = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, illegal};
        checks++;
        if (state_o === e.st) passes++;
        else $display("[TB] FAIL %s state: got %0d expected %0d", e.name, state_o, e.st);
        checks++;
        if (got === e.word) passes++;
        else $display("[TB] FAIL %s ctrl: got %05h expected %05h", e.name, got, e.word);
        checks++;
        if (!(mem_read && mem_write) && !(reg_write && pc_write)) passes++;
        else $display("[TB] FAIL %s exclusive enables: got %05h expected no overlap", e.name, got);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        applyStimulus(1, 4'd0, 0, 1, 4'd0, 17'h0, "reset0");
        applyStimulus(1, 4'd0, 0, 1, 4'd0, 17'h0, "reset1");

        // R-type: 0,1,6,7
        applyStimulus(0, 4'd0, 0, 1, 4'd0,  W_FETCH,  "rt_fetch");
        applyStimulus(0, 4'd0, 0, 1, 4'd1,  W_DECODE, "rt_decode");
        applyStimulus(0, 4'd0, 0, 1, 4'd6,  W_RTEXE,  "rt_exe");
        applyStimulus(0, 4'd0, 0, 1, 4'd7,  W_RTWB,   "rt_wb");

        // lw with two memory wait states and one fetch wait state
        applyStimulus(0, 4'd5, 0, 0, 4'd0,  W_FSTALL, "lw_fetch_stall");
        applyStimulus(0, 4'd5, 0, 1, 4'd0,  W_FETCH,  "lw_fetch");
        applyStimulus(0, 4'd5, 0, 1, 4'd1,  W_DECODE, "lw_decode");
        applyStimulus(0, 4'd5, 0, 0, 4'd2,  W_MEMADR, "lw_memadr");
        applyStimulus(0, 4'd5, 0, 0, 4'd3,  W_MEMRD,  "lw_memrd_w0");
        applyStimulus(0, 4'd5, 0, 0, 4'd3,  W_MEMRD,  "lw_memrd_w1");
        applyStimulus(0, 4'd5, 0, 1, 4'd3,  W_MEMRD,  "lw_memrd");
        applyStimulus(0, 4'd5, 0, 1, 4'd4,  W_MEMWB,  "lw_memwb");

        // beq taken / not taken, bne taken / not taken
        applyStimulus(0, 4'd7, 1, 1, 4'd0,  W_FETCH,  "beq_t_fetch");
        applyStimulus(0, 4'd7, 1, 1, 4'd1,  W_DECODE, "beq_t_decode");
        applyStimulus(0, 4'd7, 1, 1, 4'd10, W_BR_T,   "beq_taken");
        applyStimulus(0, 4'd7, 0, 1, 4'd0,  W_FETCH,  "beq_n_fetch");
        applyStimulus(0, 4'd7, 0, 1, 4'd1,  W_DECODE, "beq_n_decode");
        applyStimulus(0, 4'd7, 0, 1, 4'd10, W_BR_N,   "beq_not_taken");
        applyStimulus(0, 4'd8, 0, 1, 4'd0,  W_FETCH,  "bne_t_fetch");
        applyStimulus(0, 4'd8, 0, 1, 4'd1,  W_DECODE, "bne_t_decode");
        applyStimulus(0, 4'd8, 0, 1, 4'd10, W_BR_T,   "bne_taken");
        applyStimulus(0, 4'd8, 1, 1, 4'd0,  W_FETCH,  "bne_n_fetch");
        applyStimulus(0, 4'd8, 1, 1, 4'd1,  W_DECODE, "bne_n_decode");
        applyStimulus(0, 4'd8, 1, 1, 4'd10, W_BR_N,   "bne_not_taken");

        // ori then addi
        applyStimulus(0, 4'd3, 0, 1, 4'd0,  W_FETCH,  "ori_fetch");
        applyStimulus(0, 4'd3, 0, 1, 4'd1,  W_DECODE, "ori_decode");
        applyStimulus(0, 4'd3, 0, 1, 4'd8,  SRCA | SRCB_IMM | OP_OR,  "ori_exe");
        applyStimulus(0, 4'd3, 0, 1, 4'd9,  RW,       "ori_wb");
        applyStimulus(0, 4'd1, 0, 1, 4'd0,  W_FETCH,  "addi_fetch");
        applyStimulus(0, 4'd1, 0, 1, 4'd1,  W_DECODE, "addi_decode");
        applyStimulus(0, 4'd1, 0, 1, 4'd8,  SRCA | SRCB_IMM | OP_ADD, "addi_exe");
        applyStimulus(0, 4'd1, 0, 1, 4'd9,  RW,       "addi_wb");

        // jump
        applyStimulus(0, 4'd9, 0, 1, 4'd0,  W_FETCH,  "j_fetch");
        applyStimulus(0, 4'd9, 0, 1, 4'd1,  W_DECODE, "j_decode");
        applyStimulus(0, 4'd9, 0, 1, 4'd11, W_JUMP,   "j_jump");

        // sw stalled in MEMWR, then asynchronous reset mid-cycle
        applyStimulus(0, 4'd6, 0, 1, 4'd0,  W_FETCH,  "sw_fetch");
        applyStimulus(0, 4'd6, 0, 1, 4'd1,  W_DECODE, "sw_decode");
        applyStimulus(0, 4'd6, 0, 0, 4'd2,  W_MEMADR, "sw_memadr");
        applyStimulus(0, 4'd6, 0, 0, 4'd5,  W_MEMWR,  "sw_memwr");
        @(negedge clk);
        #2;
        rst = 1'b1;
        pushExpect("async_rst", 4'd0, 17'h0);
        #1;
        ->sample_now;
        applyStimulus(1, 4'd6, 0, 1, 4'd0,  17'h0,    "rst_hold");

        // sw completing normally
        applyStimulus(0, 4'd6, 0, 1, 4'd0,  W_FETCH,  "sw2_fetch");
        applyStimulus(0, 4'd6, 0, 1, 4'd1,  W_DECODE, "sw2_decode");
        applyStimulus(0, 4'd6, 0, 1, 4'd2,  W_MEMADR, "sw2_memadr");
        applyStimulus(0, 4'd6, 0, 1, 4'd5,  W_MEMWR,  "sw2_memwr");

        // illegal opcode: sticky until reset
        applyStimulus(0, 4'hF, 0, 1, 4'd0,  W_FETCH,  "ill_fetch");
        applyStimulus(0, 4'hF, 0, 1, 4'd1,  W_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 4'h0, 0, 1, 4'd12, ILL, "ill_hold");
        applyStimulus(1, 4'h0, 0, 0, 4'd0,  17'h0,    "ill_rst");
        applyStimulus(0, 4'h0, 0, 0, 4'd0,  W_FSTALL, "post_rst_fetch");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
